pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central sequencer for the five-stage MIPS pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It generates every stage enable and flush from debug-unit run/step/stop commands, load-use hazards, taken branches resolved in ID, and the HALT instruction. HALT is tracked from fetch through writeback so that the pipeline drains cleanly before freezing. It sits between the debug unit and the datapath and replaces per-stage ad-hoc stall wiring.

## Interface

Parameters:
- `REG_ADDR_SIZE`, 5, register address width.
- `CYCLE_COUNT_SIZE`, 32, width of the executed-cycle counter.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_cmd_run`  in  1  one-cycle pulse; enter continuous run.
- `i_cmd_step`  in  1  one-cycle pulse; advance pipeline one cycle.
- `i_cmd_stop`  in  1  one-cycle pulse; pause continuous run.
- `i_if_halt`  in  1  HALT opcode decoded on the instruction currently fetched.
- `i_wb_halt`  in  1  HALT present in the MEM/WB register.
- `i_branch_taken`  in  1  taken branch/jump resolved in ID this cycle.
- `i_id_ex_mem_read`  in  1  load instruction in ID/EX.
- `i_id_ex_rt`  in  REG_ADDR_SIZE  load destination register in ID/EX.
- `i_if_id_rs`, `i_if_id_rt`  in  REG_ADDR_SIZE  source registers of the instruction in IF/ID.
- `o_pc_enable`  out  1  PC update enable.
- `o_if_id_enable`, `o_if_id_flush`  out  1  IF/ID control.
- `o_id_ex_enable`, `o_id_ex_flush`  out  1  ID/EX control.
- `o_pipe_enable`  out  1  EX/MEM and MEM/WB enable.
- `o_stalled`  out  1  load-use stall active this cycle.
- `o_state`  out  3  current state: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- `o_cycle_count`  out  CYCLE_COUNT_SIZE  executed-cycle count (present only with the macro below).

## Operation

- Registered state: one-hot or binary, designer's choice; `o_state` always carries the binary encoding.
- Pipeline activity: `active` = state ∈ {RUN, STEP, DRAIN}.
- Load-use detection: `load_use` = `i_id_ex_mem_read` && `i_id_ex_rt` ≠ 0 && (`i_id_ex_rt` == `i_if_id_rs` || `i_id_ex_rt` == `i_if_id_rt`).
- Output equations (all zero when not `active`):
  - `o_pipe_enable` = `o_id_ex_enable` = `active`.
  - `o_stalled` = `o_id_ex_flush` = `active` && `load_use`.
  - `o_if_id_enable` = `active` && !`load_use`.
  - `o_pc_enable` = `active` && !`load_use` && state ≠ DRAIN && !`i_if_halt`.
  - `o_if_id_flush` = `active` && !`load_use` && (`i_branch_taken` || state == DRAIN).
- HALT capture: `halt_cap` = `o_if_id_enable` && !`o_if_id_flush` && `i_if_halt`.
- Transitions:
  - IDLE: `i_cmd_run` → RUN; else `i_cmd_step` → STEP (run wins if both are asserted).
  - RUN: `halt_cap` → DRAIN; else `i_cmd_stop` → IDLE.
  - STEP: `halt_cap` → DRAIN; else → IDLE. STEP always lasts exactly one cycle.
  - DRAIN: `i_wb_halt` → HALTED; commands ignored. A drain entered from STEP runs to completion without further steps.
  - HALTED: terminal; only `i_reset` leaves it.
- Precedence rules:
  - Stall beats branch flush: a branch that coincides with `load_use` is re-evaluated on the next cycle.
  - A HALT on a branch-flushed wrong path is discarded, and the state does not change.

## Timing

- Reset: state IDLE and `o_cycle_count` 0. All enables, flushes and `o_stalled` are 0 in the cycle following reset.
- Control outputs are combinational from the registered state and the current hazard inputs. They are valid in the same cycle and are used at the next posedge.
- Commands are sampled at the posedge; the first active cycle is the one after the command.
- Stall latency: a load-use stall lasts exactly one cycle; the bubble appears in ID/EX at the next edge.
- HALT latency: capture into IF/ID → DRAIN. HALTED is reached the cycle after `i_wb_halt`, i.e. 4 cycles after capture without stalls.
- Reset mid-operation: immediate return to IDLE at the next edge. No flush pulses are emitted.

## Configuration

- `PIPELINE_CTRL_CYCLE_COUNTER_EN` defined:
  - `o_cycle_count` increments by 1 on every cycle with `o_pipe_enable` = 1, wrapping at 2^CYCLE_COUNT_SIZE.
  - Counts stall cycles; holds in IDLE and HALTED; clears on reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan

- Reset, then `i_cmd_step` ×3 pulses spaced 2 cycles apart → exactly 3 single-cycle pulses of `o_pc_enable`; state IDLE between pulses; `o_cycle_count` = 3.
- RUN, with `i_id_ex_mem_read`=1, `i_id_ex_rt`=8, `i_if_id_rs`=8 for one cycle → `o_stalled`=1, `o_pc_enable`=0, `o_if_id_enable`=0, `o_id_ex_flush`=1 for that cycle only. Same stimulus with `i_id_ex_rt`=0 → no stall.
- RUN with `i_branch_taken`=1 → `o_if_id_flush`=1, `o_pc_enable`=1. With `load_use` also asserted → `o_if_id_flush`=0 and the stall is taken.
- RUN, `i_if_halt`=1 → DRAIN next cycle with `o_pc_enable`=0 and `o_if_id_flush`=1; `i_wb_halt` 4 cycles later → `o_state`=4, all enables 0. Subsequent `i_cmd_run` is ignored.
- `i_if_halt` and `i_branch_taken` asserted together in RUN → state stays RUN.
- `i_cmd_stop` in RUN → IDLE next cycle, counter frozen. Reset asserted during DRAIN → IDLE with all outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle between the sequencer and its neighbours.
// Carries the debug commands, hazard/HALT status from the datapath and the
// per-stage enables/flushes that the sequencer returns.
//   master : debug unit / datapath side (drives commands and hazard status)
//   slave  : pipeline_ctrl side (drives stage enables and flushes)
// Parameter: REG_ADDR_SIZE - register address width.
interface pipeline_ctrl_if #(
  parameter int unsigned REG_ADDR_SIZE = 5
);
  // Debug-unit commands (one-cycle pulses)
  logic                     i_cmd_run;
  logic                     i_cmd_step;
  logic                     i_cmd_stop;
  // Datapath status
  logic                     i_if_halt;
  logic                     i_wb_halt;
  logic                     i_branch_taken;
  logic                     i_id_ex_mem_read;
  logic [REG_ADDR_SIZE-1:0] i_id_ex_rt;
  logic [REG_ADDR_SIZE-1:0] i_if_id_rs;
  logic [REG_ADDR_SIZE-1:0] i_if_id_rt;
  // Stage controls
  logic                     o_pc_enable;
  logic                     o_if_id_enable;
  logic                     o_if_id_flush;
  logic                     o_id_ex_enable;
  logic                     o_id_ex_flush;
  logic                     o_pipe_enable;
  logic                     o_stalled;
  logic [2:0]               o_state;

  modport master (
    output i_cmd_run, i_cmd_step, i_cmd_stop,
    output i_if_halt, i_wb_halt, i_branch_taken,
    output i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt,
    input  o_pc_enable, o_if_id_enable, o_if_id_flush,
    input  o_id_ex_enable, o_id_ex_flush, o_pipe_enable, o_stalled, o_state
  );

  modport slave (
    input  i_cmd_run, i_cmd_step, i_cmd_stop,
    input  i_if_halt, i_wb_halt, i_branch_taken,
    input  i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt,
    output o_pc_enable, o_if_id_enable, o_if_id_flush,
    output o_id_ex_enable, o_id_ex_flush, o_pipe_enable, o_stalled, o_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the five-stage pipeline registers (PC, IF/ID, ID/EX,
// EX/MEM, MEM/WB). Turns run/step/stop commands, load-use hazards, taken
// branches and HALT into stage enables and flushes, and drains the pipeline
// after a HALT is captured into IF/ID before freezing.
// Ports:
//   i_clk          clock
//   i_reset        synchronous, active-high reset
//   bus            pipeline_ctrl_if.slave (commands, hazards, stage controls)
//   o_cycle_count  executed-cycle counter (only with the macro below)
// Optional feature macro: PIPELINE_CTRL_CYCLE_COUNTER_EN
//   defined   -> CYCLE_COUNT_SIZE parameter and o_cycle_count port exist,
//                counting every cycle with o_pipe_enable = 1 (wraps).
//   undefined -> no counter, no port; all other behaviour identical.
// Stage controls are combinational from the registered state and the
// current hazard inputs; they are consumed at the next posedge.
module pipeline_ctrl #(
  parameter int unsigned REG_ADDR_SIZE = 5
`ifdef PIPELINE_CTRL_CYCLE_COUNTER_EN
  , parameter int unsigned CYCLE_COUNT_SIZE = 32
`endif
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  pipeline_ctrl_if.slave              bus
`ifdef PIPELINE_CTRL_CYCLE_COUNTER_EN
  , output logic [CYCLE_COUNT_SIZE-1:0] o_cycle_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [REG_ADDR_SIZE-1:0] ex_rt;
  logic [REG_ADDR_SIZE-1:0] id_rs;
  logic [REG_ADDR_SIZE-1:0] id_rt;
  logic                     active;
  logic                     load_use;
  logic                     if_id_enable;
  logic                     if_id_flush;
  logic                     halt_cap;

  assign ex_rt = bus.i_id_ex_rt;
  assign id_rs = bus.i_if_id_rs;
  assign id_rt = bus.i_if_id_rt;

  // Load in EX feeding a source of the instruction in ID; $zero never hazards.
  assign load_use = bus.i_id_ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  assign active = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);

  // Stall beats branch flush: a stalled IF/ID holds, so no flush that cycle.
  assign if_id_enable = active && !load_use;
  assign if_id_flush  = if_id_enable && (bus.i_branch_taken || (state_q == DRAIN));

  // HALT only counts when it actually lands in IF/ID (not stalled, not flushed).
  assign halt_cap = if_id_enable && !if_id_flush && bus.i_if_halt;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stage controls
  always_comb begin
    state_d            = state_q;
    bus.o_pc_enable    = 1'b0;
    bus.o_if_id_enable = 1'b0;
    bus.o_if_id_flush  = 1'b0;
    bus.o_id_ex_enable = 1'b0;
    bus.o_id_ex_flush  = 1'b0;
    bus.o_pipe_enable  = 1'b0;
    bus.o_stalled      = 1'b0;
    bus.o_state        = state_q;

    if (active) begin
      bus.o_pipe_enable  = 1'b1;
      bus.o_id_ex_enable = 1'b1;
      bus.o_stalled      = load_use;
      bus.o_id_ex_flush  = load_use;
      bus.o_if_id_enable = if_id_enable;
      bus.o_if_id_flush  = if_id_flush;
      // PC freezes while draining and on the HALT fetch itself.
      bus.o_pc_enable    = if_id_enable && (state_q != DRAIN) && !bus.i_if_halt;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.i_cmd_run) begin
          state_d = RUN;
        end else if (bus.i_cmd_step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (halt_cap) begin
          state_d = DRAIN;
        end else if (bus.i_cmd_stop) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        state_d = halt_cap ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (bus.i_wb_halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef PIPELINE_CTRL_CYCLE_COUNTER_EN
  logic [CYCLE_COUNT_SIZE-1:0] count_q, count_d;

  // Executed-cycle count: every active cycle, stall cycles included.
  always_comb begin
    count_d = count_q;
    if (active) begin
      count_d = count_q + CYCLE_COUNT_SIZE'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_cycle_count = count_q;
`endif

endmodule
